panda_data_mem: RTL

// - Responder end of the core data-memory port driven by the MEM stage (addr/wdata/we out, rdata in).
// - Byte-writable data RAM with same-cycle (combinational) read, plus a small MMIO window:
//   64-bit free-running timer with compare interrupt and a byte TX FIFO drained by an external sink.
// - Sits outside panda_core at SoC level; the MEM stage registers rdata at the end of the access cycle.

---
 rtl/panda_pkg.sv | 29 ++
 rtl/panda_data_mem_if.sv | 11 +
 rtl/panda_fifo.sv | 48 ++++
 rtl/panda_data_mem.sv | 121 ++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared definitions for the panda data-memory responder: MMIO register offsets,
// address-decode select type and a byte-strobe merge helper.
package panda_pkg;

  localparam logic [31:0] DMEM_TX_DATA     = 32'h00;
  localparam logic [31:0] DMEM_TX_STATUS   = 32'h04;
  localparam logic [31:0] DMEM_MTIME_LO    = 32'h08;
  localparam logic [31:0] DMEM_MTIME_HI    = 32'h0C;
  localparam logic [31:0] DMEM_MTIMECMP_LO = 32'h10;
  localparam logic [31:0] DMEM_MTIMECMP_HI = 32'h14;

  typedef enum logic {
    DMEM_SEL_RAM,
    DMEM_SEL_MMIO
  } dmem_sel_e;

  // Replace the bytes of old_word selected by strobe with those of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strobe[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/panda_data_mem_if.sv
// Core data-memory port: the MEM stage (master) presents address/data/strobes,
// the data memory (slave) returns same-cycle read data.
interface panda_data_mem_if;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic [31:0] data_rdata;

  modport master (output data_addr, output data_wdata, output data_we, input data_rdata);
  modport slave  (input data_addr, input data_wdata, input data_we, output data_rdata);
endinterface

// File: rtl/panda_fifo.sv
// Generic synchronous FIFO with asynchronous active-low reset. No fall-through:
// a pushed word appears at rdata the cycle after the push. rdata is 0 when empty.
module panda_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign count   = count_reg;
  assign rdata   = empty ? '0 : mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/panda_data_mem.sv
// Core data memory: byte-writable RAM with combinational read plus an MMIO window
// (TX byte FIFO, optional 64-bit timer enabled by defining PANDA_DMEM_TIMER_EN).
module panda_data_mem #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          TX_DEPTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  panda_data_mem_if.slave         bus,
  output logic                    tx_valid_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ready_i,
  output logic                    timer_irq_o
);
  import panda_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  dmem_sel_e      sel;
  logic [AW-1:0]  ram_idx;
  logic [31:0]    mmio_off;
  logic [31:0]    mmio_rdata;
  logic           mmio_wr;
  logic [31:0]    mem [DEPTH];

  assign sel      = (bus.data_addr >= MMIO_BASE) ? DMEM_SEL_MMIO : DMEM_SEL_RAM;
  assign ram_idx  = bus.data_addr[AW+1:2];
  assign mmio_off = (bus.data_addr & ~32'h3) - MMIO_BASE;
  assign mmio_wr  = (sel == DMEM_SEL_MMIO) && (bus.data_we != 4'b0);

  // RAM aliases modulo DEPTH; reads see the contents before this cycle's write.
  always_ff @(posedge clk_i) begin
    if (sel == DMEM_SEL_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_we[i]) mem[ram_idx][i*8 +: 8] <= bus.data_wdata[i*8 +: 8];
      end
    end
  end

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic [31:0]   tx_status;

  assign tx_push    = (sel == DMEM_SEL_MMIO) && (mmio_off == DMEM_TX_DATA) && bus.data_we[0];
  assign tx_valid_o = !tx_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign tx_status  = {16'b0, 8'(tx_count), 6'b0, tx_empty, tx_full};

  panda_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (tx_push),
    .wdata (bus.data_wdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

`ifdef PANDA_DMEM_TIMER_EN
  logic [63:0] mtime_reg, mtime_next, mtimecmp_reg, mtimecmp_next;
  logic        irq_reg;

  // Software writes to either mtime half freeze the whole counter for that cycle.
  always_comb begin
    mtime_next    = mtime_reg + 64'd1;
    mtimecmp_next = mtimecmp_reg;
    if (mmio_wr) begin
      case (mmio_off)
        DMEM_MTIME_LO:    mtime_next = {mtime_reg[63:32],
                                        byte_merge(mtime_reg[31:0], bus.data_wdata, bus.data_we)};
        DMEM_MTIME_HI:    mtime_next = {byte_merge(mtime_reg[63:32], bus.data_wdata, bus.data_we),
                                        mtime_reg[31:0]};
        DMEM_MTIMECMP_LO: mtimecmp_next[31:0]  = byte_merge(mtimecmp_reg[31:0], bus.data_wdata,
                                                            bus.data_we);
        DMEM_MTIMECMP_HI: mtimecmp_next[63:32] = byte_merge(mtimecmp_reg[63:32], bus.data_wdata,
                                                            bus.data_we);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_reg    <= '0;
      mtimecmp_reg <= '1;
      irq_reg      <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      irq_reg      <= (mtime_next >= mtimecmp_next);
    end
  end

  assign timer_irq_o = irq_reg;
`else
  assign timer_irq_o = 1'b0;
`endif

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      DMEM_TX_STATUS:   mmio_rdata = tx_status;
`ifdef PANDA_DMEM_TIMER_EN
      DMEM_MTIME_LO:    mmio_rdata = mtime_reg[31:0];
      DMEM_MTIME_HI:    mmio_rdata = mtime_reg[63:32];
      DMEM_MTIMECMP_LO: mmio_rdata = mtimecmp_reg[31:0];
      DMEM_MTIMECMP_HI: mmio_rdata = mtimecmp_reg[63:32];
`else
      DMEM_TX_DATA, DMEM_MTIME_LO, DMEM_MTIME_HI,
      DMEM_MTIMECMP_LO, DMEM_MTIMECMP_HI: mmio_rdata = '0;
`endif
      default:          mmio_rdata = '0;
    endcase
  end

  assign bus.data_rdata = (sel == DMEM_SEL_RAM) ? mem[ram_idx] : mmio_rdata;
endmodule
